// File: rtl/decode_issue_ctrl.sv
// Single-entry decode/issue stage with a register scoreboard for RAW/WAW hazards.
// Optional build macro WB_BYPASS_EN: a writeback clearing a busy bit unblocks issue in that same cycle.
module decode_issue_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [31:0]            in_inst,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [6:0]             out_opcode,
    output logic [4:0]             out_dst,
    output logic [4:0]             out_src1,
    output logic [4:0]             out_src2,
    output logic [9:0]             out_imm,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_reg,
    input  logic                   flush,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [31:0]            ir_q, ir_d;
    logic                   ir_v_q, ir_v_d;
    logic [31:0]            busy_q, busy_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [31:0] wb_clr;
    logic [31:0] iss_set;
    logic [31:0] busy_chk;
    logic        hazard;
    logic        issue;
    logic        load;

    assign out_opcode = ir_q[31:25];
    assign out_dst    = ir_q[24:20];
    assign out_src1   = ir_q[19:15];
    assign out_src2   = ir_q[14:10];
    assign out_imm    = ir_q[9:0];
    assign stall_cnt  = stall_cnt_q;

    always_comb begin
        wb_clr = '0;
        if (wb_valid && (wb_reg != 5'd0)) begin
            wb_clr[wb_reg] = 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    // A register retiring this cycle is already free for the hazard check.
    assign busy_chk = busy_q & ~wb_clr;
`else
    assign busy_chk = busy_q;
`endif

    always_comb begin
        hazard    = ir_v_q && (busy_chk[out_src1] || busy_chk[out_src2] || busy_chk[out_dst]);
        out_valid = ir_v_q && !hazard && !flush;
        issue     = out_valid && out_ready;
        in_ready  = !flush && (!ir_v_q || issue);
        load      = in_valid && in_ready;
    end

    always_comb begin
        ir_d   = ir_q;
        ir_v_d = ir_v_q;
        if (flush) begin
            ir_v_d = 1'b0;
        end else if (load) begin
            ir_d   = in_inst;
            ir_v_d = 1'b1;
        end else if (issue) begin
            ir_v_d = 1'b0;
        end
    end

    // Set is applied after clear so a same-cycle issue keeps its destination busy.
    always_comb begin
        iss_set = '0;
        if (issue && (out_dst != 5'd0)) begin
            iss_set[out_dst] = 1'b1;
        end
        busy_d    = (busy_q & ~wb_clr) | iss_set;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ir_v_q && hazard && !flush && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q        <= '0;
            ir_v_q      <= 1'b0;
            busy_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            ir_q        <= ir_d;
            ir_v_q      <= ir_v_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl; issued words are matched against a queue of accepted instructions.
module tb_decode_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_opcode;
    logic [4:0]  out_dst;
    logic [4:0]  out_src1;
    logic [4:0]  out_src2;
    logic [9:0]  out_imm;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic        flush;
    logic [15:0] stall_cnt;

    int          checks;
    int          errors;
    int          issues;
    int          exp_stall;
    logic [31:0] exp_q[$];

    decode_issue_ctrl #(.STALL_CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_opcode(out_opcode),
        .out_dst   (out_dst),
        .out_src1  (out_src1),
        .out_src2  (out_src2),
        .out_imm   (out_imm),
        .wb_valid  (wb_valid),
        .wb_reg    (wb_reg),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [4:0] s2,
                                       input logic [9:0] imm);
        return {op, d, s1, s2, imm};
    endfunction

    // Negedge sample point; any issue seen here must match the oldest accepted word.
    task automatic sample();
        logic [31:0] e;
        logic [31:0] got;
        @(negedge clk);
        if (rst && out_valid && out_ready) begin
            got = {out_opcode, out_dst, out_src1, out_src2, out_imm};
            checks++;
            issues++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got %h, required no issue", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL issue_fields: got %h, required %h", got, e);
                end
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_reg = 5'd0;
        out_ready = 1'b1; in_valid = 1'b1; in_inst = mk(7'h7f, 5'd9, 5'd1, 5'd2, 10'h3ff);
        #23;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
        checks++; if ({out_opcode, out_dst, out_src1, out_src2, out_imm} !== 32'h0) begin
            errors++; $display("FAIL rst_fields: got %h, required 0", {out_opcode, out_dst, out_src1, out_src2, out_imm}); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall: got %0d, required 0", stall_cnt); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_stall = 0;
    endtask

    task automatic test_basic();
        in_inst = mk(7'd1, 5'd3, 5'd0, 5'd0, 10'd5); in_valid = 1'b1; exp_q.push_back(in_inst);
        sample();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b, required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b, required 0", out_valid); end
        adv();
        in_valid = 1'b0;
        sample();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b, required 1", out_valid); end
        checks++; if (out_dst !== 5'd3) begin errors++; $display("FAIL basic_dst: got %0d, required 3", out_dst); end
        checks++; if (out_imm !== 10'd5) begin errors++; $display("FAIL basic_imm: got %0d, required 5", out_imm); end
        adv();
    endtask

    // Probe already loaded and stalled on register r; writeback r and expect issue.
    task automatic release_and_issue(input logic [4:0] r);
        wb_valid = 1'b1; wb_reg = r;
        sample();
`ifdef WB_BYPASS_EN
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bypass_issue r%0d: got %b, required 1", r, out_valid); end
        adv();
        wb_valid = 1'b0;
`else
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wb_cycle_stall r%0d: got %b, required 0", r, out_valid); end
        adv();
        exp_stall++;
        wb_valid = 1'b0;
        sample();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL post_wb_issue r%0d: got %b, required 1", r, out_valid); end
        adv();
`endif
        sample();
        checks++; if (stall_cnt !== 16'(exp_stall)) begin
            errors++; $display("FAIL release_stall r%0d: got %0d, required %0d", r, stall_cnt, exp_stall); end
        adv();
    endtask

    task automatic test_raw();
        in_inst = mk(7'd2, 5'd0, 5'd3, 5'd0, 10'd7); in_valid = 1'b1; exp_q.push_back(in_inst);
        sample();
        adv();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_hold k%0d: got %b, required 0", k, out_valid); end
            checks++; if (stall_cnt !== 16'(exp_stall)) begin
                errors++; $display("FAIL raw_stall k%0d: got %0d, required %0d", k, stall_cnt, exp_stall); end
            adv();
            exp_stall++;
        end
        release_and_issue(5'd3);
    endtask

    task automatic test_hold();
        logic [31:0] a;
        logic [31:0] b;
        a = mk(7'd3, 5'd6, 5'd0, 5'd0, 10'h155);
        b = mk(7'd4, 5'd7, 5'd0, 5'd0, 10'h2aa);
        out_ready = 1'b0; in_inst = a; in_valid = 1'b1; exp_q.push_back(a);
        sample();
        adv();
        in_inst = b;
        for (int k = 0; k < 5; k++) begin
            sample();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid k%0d: got %b, required 1", k, out_valid); end
            checks++; if ({out_opcode, out_dst, out_src1, out_src2, out_imm} !== a) begin
                errors++; $display("FAIL hold_ir k%0d: got %h, required %h", k, {out_opcode, out_dst, out_src1, out_src2, out_imm}, a); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready k%0d: got %b, required 0", k, in_ready); end
            adv();
        end
        out_ready = 1'b1; exp_q.push_back(b);
        sample();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b, required 1", in_ready); end
        adv();
        in_valid = 1'b0;
        sample();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: got %b, required 1", out_valid); end
        adv();
        wb_valid = 1'b1; wb_reg = 5'd6; sample(); adv();
        wb_reg = 5'd7; sample(); adv();
        wb_valid = 1'b0;
    endtask

    task automatic test_flush();
        in_inst = mk(7'd5, 5'd8, 5'd0, 5'd0, 10'd1); in_valid = 1'b1; exp_q.push_back(in_inst);
        sample(); adv();
        in_valid = 1'b0;
        sample(); adv();
        in_inst = mk(7'd6, 5'd0, 5'd8, 5'd0, 10'd2); in_valid = 1'b1;
        sample(); adv();
        in_valid = 1'b0;
        sample();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stalled_in_ready: got %b, required 0", in_ready); end
        adv();
        exp_stall++;
        flush = 1'b1; in_valid = 1'b1; in_inst = mk(7'd7, 5'd9, 5'd0, 5'd0, 10'd3);
        sample();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_cycle: got valid %b ready %b, required 0 0", out_valid, in_ready); end
        adv();
        flush = 1'b0; in_valid = 1'b0;
        sample();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL after_flush: got valid %b ready %b, required 0 1", out_valid, in_ready); end
        checks++; if (stall_cnt !== 16'(exp_stall)) begin
            errors++; $display("FAIL flush_stall: got %0d, required %0d", stall_cnt, exp_stall); end
        adv();
        in_inst = mk(7'd6, 5'd0, 5'd8, 5'd0, 10'd4); in_valid = 1'b1; exp_q.push_back(in_inst);
        sample(); adv();
        in_valid = 1'b0;
        sample();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kept_busy: got %b, required 0", out_valid); end
        adv();
        exp_stall++;
        release_and_issue(5'd8);
    endtask

    task automatic test_set_wins();
        in_inst = mk(7'd8, 5'd4, 5'd0, 5'd0, 10'd6); in_valid = 1'b1; exp_q.push_back(in_inst);
        sample(); adv();
        in_valid = 1'b0; wb_valid = 1'b1; wb_reg = 5'd4;
        sample();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL setwin_issue: got %b, required 1", out_valid); end
        adv();
        wb_valid = 1'b0;
        in_inst = mk(7'd9, 5'd0, 5'd4, 5'd0, 10'd7); in_valid = 1'b1; exp_q.push_back(in_inst);
        sample(); adv();
        in_valid = 1'b0;
        sample();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL setwin_busy: got %b, required 0", out_valid); end
        adv();
        exp_stall++;
        release_and_issue(5'd4);
    endtask

    task automatic test_stream();
        int base;
        wb_valid = 1'b1; wb_reg = 5'd12;
        sample(); adv();
        wb_valid = 1'b0;
        in_inst = mk(7'd10, 5'd0, 5'd12, 5'd0, 10'd8); in_valid = 1'b1; exp_q.push_back(in_inst);
        sample(); adv();
        in_valid = 1'b0;
        sample();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL idle_wb: got %b, required 1", out_valid); end
        adv();
        base = issues;
        for (int i = 0; i < 8; i++) begin
            in_inst = mk(7'($urandom_range(0, 127)), 5'd0, 5'd0, 5'd0, 10'($urandom_range(0, 1023)));
            in_valid = 1'b1; exp_q.push_back(in_inst);
            sample();
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready i%0d: got %b, required 1", i, in_ready); end
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid i%0d: got %b, required 1", i, out_valid); end
            end
            adv();
        end
        in_valid = 1'b0;
        sample(); adv();
        checks++; if (issues - base !== 8) begin errors++; $display("FAIL stream_count: got %0d, required 8", issues - base); end
        checks++; if (stall_cnt !== 16'(exp_stall)) begin
            errors++; $display("FAIL stream_stall: got %0d, required %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_reset_mid_stall();
        in_inst = mk(7'd11, 5'd11, 5'd0, 5'd0, 10'd9); in_valid = 1'b1; exp_q.push_back(in_inst);
        sample(); adv();
        in_valid = 1'b0;
        sample(); adv();
        in_inst = mk(7'd11, 5'd0, 5'd11, 5'd0, 10'd9); in_valid = 1'b1;
        sample(); adv();
        in_valid = 1'b0;
        sample(); adv();
        sample(); adv();
        exp_stall += 2;
        checks++; if (stall_cnt !== 16'(exp_stall)) begin
            errors++; $display("FAIL pre_reset_stall: got %0d, required %0d", stall_cnt, exp_stall); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL async_stall: got %0d, required 0", stall_cnt); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL async_hs: got valid %b ready %b, required 0 1", out_valid, in_ready); end
        checks++; if ({out_opcode, out_dst, out_src1, out_src2, out_imm} !== 32'h0) begin
            errors++; $display("FAIL async_fields: got %h, required 0", {out_opcode, out_dst, out_src1, out_src2, out_imm}); end
        exp_stall = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        in_inst = mk(7'd12, 5'd0, 5'd11, 5'd0, 10'd1); in_valid = 1'b1; exp_q.push_back(in_inst);
        sample(); adv();
        in_valid = 1'b0;
        sample();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_cleared_busy: got %b, required 1", out_valid); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL post_reset_stall: got %0d, required 0", stall_cnt); end
        adv();
    endtask

    initial begin
        checks = 0; errors = 0; issues = 0; exp_stall = 0;
        test_reset();
        test_basic();
        test_raw();
        test_hold();
        test_flush();
        test_set_wins();
        test_stream();
        test_reset_mid_stall();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL leftover_expected: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_issue_ctrl.md
DECODE_ISSUE_CTRL -- requirements
Module: decode_issue_ctrl

Interface
REQ-001 Parameter: STALL_CNT_W, 16, width of the saturating stall counter.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  fetch presents an instruction.
REQ-005 in_inst  input  32  instruction word; opcode[31:25], dst[24:20], src1[19:15], src2[14:10], imm[9:0].
REQ-006 in_ready  output  1  block accepts in_inst this cycle.
REQ-007 out_valid  output  1  decoded instruction may issue.
REQ-008 out_ready  input  1  execute accepts the issued instruction.
REQ-009 out_opcode/out_dst/out_src1/out_src2/out_imm  output  7/5/5/5/10  fields of the held instruction.
REQ-010 wb_valid  input  1  writeback completes this cycle.
REQ-011 wb_reg  input  5  register written back.
REQ-012 flush  input  1  discard the held instruction.
REQ-013 stall_cnt  output  STALL_CNT_W  cycles lost to hazards.

Function
REQ-014 The block SHALL hold a single-entry instruction register (IR) with a valid bit ir_v.
REQ-015 Output fields SHALL be bit slices of IR, driven combinationally.
REQ-016 busy[31:0] scoreboard SHALL be kept; busy[0] SHALL always read 0.
REQ-017 hazard SHALL be 1 when ir_v and any of busy[src1], busy[src2], busy[dst] is set (RAW and WAW checks).
REQ-018 out_valid SHALL be ir_v && !hazard && !flush.
REQ-019 Issue SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL be !flush && (!ir_v || issue).
REQ-021 Load SHALL occur when in_valid && in_ready: IR <= in_inst and ir_v <= 1 on the same edge, giving 1-cycle latency from accept to earliest issue.
REQ-022 Issue without load SHALL clear ir_v; issue with load SHALL keep ir_v=1 and hold the new word (back-to-back, 1 instruction/cycle).
REQ-023 On issue with dst!=0, busy[dst] SHALL be set.
REQ-024 A wb_valid with wb_reg!=0 SHALL clear busy[wb_reg].
REQ-025 Issue set and writeback clear of the same register in the same cycle: set SHALL win.
REQ-026 flush SHALL clear ir_v and SHALL NOT modify busy; the in_inst presented that cycle is not accepted.
REQ-027 Once out_valid=1, IR SHALL be stable and out_valid SHALL stay 1 until issue or flush.
REQ-028 stall_cnt SHALL increment each cycle with ir_v && hazard && !flush and saturate at all-ones.
REQ-029 wb_valid for a register that is not busy SHALL be harmless; busy stays 0.

Reset
REQ-030 On rst low, immediately and regardless of clk: ir_v=0, IR=0, busy=0, stall_cnt=0.
REQ-031 During reset the outputs SHALL be out_valid=0, in_ready=1, and all field outputs 0.
REQ-032 Reset asserted mid-stall SHALL discard the held instruction and all scoreboard state.

Configuration
REQ-033 Macro WB_BYPASS_EN defined: a busy bit cleared by wb_valid/wb_reg in the current cycle SHALL count as not busy for the hazard check, so issue occurs in the writeback cycle.
REQ-034 WB_BYPASS_EN undefined: the hazard check SHALL use registered busy only, so issue occurs at the earliest 1 cycle after writeback.

Verification
REQ-035 Reset release, in_valid=1, inst{op=1,dst=3,src1=0,src2=0,imm=5}, out_ready=1 -> out_valid=1 the next cycle with out_dst=3 and out_imm=5; busy[3]=1 after issue.
REQ-036 Issue dst=3, then inst{src1=3} -> out_valid=0 and stall_cnt increments each cycle; wb_valid with wb_reg=3 -> issue in the same cycle with WB_BYPASS_EN, or 1 cycle later without it.
REQ-037 Held instruction with out_ready=0 for 5 cycles -> out_valid=1 and IR constant throughout; in_ready=0.
REQ-038 Stalled IR, flush=1 with in_valid=1 -> next cycle ir_v=0, input not taken, busy unchanged, in_ready=1.
REQ-039 Issue dst=4 in the same cycle as wb_valid with wb_reg=4 -> busy[4]=1 afterwards.
REQ-040 inst{dst=0,src1=0} stream with out_ready=1 -> one issue per cycle, busy stays 0, stall_cnt=0.
